// File: rtl/mem_1r1w_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_1r1w_fifo_ctrl
// Brief    : FIFO controller around an external 1R1W memory with a 1-cycle
//            read latency, plus a 2-entry output buffer for full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module mem_1r1w_fifo_ctrl #(
    parameter int DEPTH  = 48,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_bits,
    output logic [5:0]        count,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [WIDTH-1:0]  W0_data,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [WIDTH-1:0]  R0_data
);

    localparam int                 c_MCNT_W    = ADDR_W + 1;
    localparam int                 c_COUNT_W   = 6;
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [c_MCNT_W-1:0] c_FULL     = c_MCNT_W'(DEPTH);

    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [c_MCNT_W-1:0]  r_mem_cnt;
    logic                 r_rd_inflight;
    logic [1:0]           r_ob_cnt;
    logic [WIDTH-1:0]     r_ob_data [2];
    logic [c_COUNT_W-1:0] r_count;

    logic                 w_enq_ready;
    logic                 w_enq;
    logic                 w_deq;
    logic                 w_rd;
    logic [1:0]           w_occ;
    logic [c_MCNT_W-1:0]  w_mem_cnt_nxt;
    logic [1:0]           w_ob_cnt_nxt;
    logic [1:0]           w_ob_tail;
    logic [c_COUNT_W-1:0] w_count_nxt;

    function automatic logic [ADDR_W-1:0] f_next_ptr(input logic [ADDR_W-1:0] p);
        return (p == c_LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_enq_ready = (r_mem_cnt != c_FULL);
        w_enq       = enq_valid & w_enq_ready & ~reset;
        w_deq       = (r_ob_cnt != 2'd0) & deq_ready & ~reset;
        // Slots already claimed in the output buffer: held words plus the read in flight.
        w_occ       = r_ob_cnt + {1'b0, r_rd_inflight};
        w_rd        = ~reset & (r_mem_cnt != '0)
                    & ((w_occ < 2'd2) | ((w_occ == 2'd2) & w_deq));

        w_mem_cnt_nxt = r_mem_cnt;
        if (w_enq && !w_rd) begin
            w_mem_cnt_nxt = r_mem_cnt + 1'b1;
        end else if (!w_enq && w_rd) begin
            w_mem_cnt_nxt = r_mem_cnt - 1'b1;
        end

        w_ob_cnt_nxt = r_ob_cnt + {1'b0, r_rd_inflight} - {1'b0, w_deq};
        // Capture lands behind whatever survives this cycle's dequeue.
        w_ob_tail    = r_ob_cnt - {1'b0, w_deq};
        w_count_nxt  = c_COUNT_W'(w_mem_cnt_nxt) + c_COUNT_W'(w_rd)
                     + c_COUNT_W'(w_ob_cnt_nxt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_mem_cnt     <= '0;
            r_rd_inflight <= 1'b0;
            r_ob_cnt      <= 2'd0;
            r_count       <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            r_mem_cnt     <= w_mem_cnt_nxt;
            r_rd_inflight <= w_rd;
            r_ob_cnt      <= w_ob_cnt_nxt;
            r_count       <= w_count_nxt;
        end
    end

    // Data registers need no reset; r_ob_cnt qualifies them.
    always_ff @(posedge clock) begin
        if (w_deq) begin
            r_ob_data[0] <= r_ob_data[1];
        end
        if (r_rd_inflight && !reset) begin
            r_ob_data[w_ob_tail[0]] <= R0_data;
        end
    end

    assign enq_ready = w_enq_ready;
    assign deq_valid = (r_ob_cnt != 2'd0);
    assign deq_bits  = r_ob_data[0];
    assign count     = r_count;
    assign W0_en     = w_enq;
    assign W0_addr   = r_wr_ptr;
    assign W0_data   = enq_bits;
    assign R0_en     = w_rd;
    assign R0_addr   = r_rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_mem_1r1w_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_1r1w_fifo_ctrl
// Brief    : Directed and randomised bench with a 1R1W memory model and a
//            queue scoreboard for mem_1r1w_fifo_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_1r1w_fifo_ctrl;

    localparam int DEPTH  = 48;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [WIDTH-1:0]  enq_bits = '0;
    logic              deq_valid;
    logic              deq_ready = 1'b0;
    logic [WIDTH-1:0]  deq_bits;
    logic [5:0]        count;
    logic [ADDR_W-1:0] W0_addr;
    logic              W0_en;
    logic [WIDTH-1:0]  W0_data;
    logic [ADDR_W-1:0] R0_addr;
    logic              R0_en;
    logic [WIDTH-1:0]  R0_data = '0;

    mem_1r1w_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
    );

    always #5 clock = ~clock;

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        if (W0_en) mem[W0_addr] <= W0_data;
        if (R0_en) R0_data <= mem[R0_addr];
    end

    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] sbq [$];
    int               exp_wa = 0;
    int               exp_ra = 0;
    int               tb_mem = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [63:0] eb, input logic dr);
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        #4;
    endtask

    // Checks the current cycle against the model, updates the model, steps a clock.
    task automatic advance();
        logic [63:0] e;
        check("count", 64'(count), 64'(sbq.size()));
        check("enq_ready", 64'(enq_ready), 64'(tb_mem != DEPTH));
        check("w0_en", 64'(W0_en), 64'(enq_valid && (tb_mem != DEPTH)));
        if (W0_en) begin
            check("w0_addr", 64'(W0_addr), 64'(exp_wa));
            check("w0_data", W0_data, enq_bits);
            exp_wa = (exp_wa == DEPTH-1) ? 0 : exp_wa + 1;
            tb_mem++;
        end
        if (R0_en) begin
            check("r0_nonempty", 64'(tb_mem > 0), 64'd1);
            check("r0_addr", 64'(R0_addr), 64'(exp_ra));
            exp_ra = (exp_ra == DEPTH-1) ? 0 : exp_ra + 1;
            tb_mem--;
        end
        if (deq_valid && deq_ready) begin
            if (sbq.size() == 0) begin
                check("deq_spurious", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("deq_bits", deq_bits, e);
            end
        end
        if (enq_valid && enq_ready) sbq.push_back(enq_bits);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 64'hDEAD, 1'b1);
            check("rst_w0_en", 64'(W0_en), 64'd0);
            check("rst_r0_en", 64'(R0_en), 64'd0);
            @(posedge clock);
            #1;
            check("rst_count", 64'(count), 64'd0);
            check("rst_deq_valid", 64'(deq_valid), 64'd0);
        end
        reset  = 1'b0;
        sbq.delete();
        exp_wa = 0;
        exp_ra = 0;
        tb_mem = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          sent;
        int          cyc;
        int          win_deq;
        logic        acc;
        logic        ev;
        logic        dr;

        @(posedge clock);
        #1;
        do_reset(3);

        // Single word latency
        drive(1'b1, 64'hA5, 1'b0);
        check("sw_enq_ready", 64'(enq_ready), 64'd1);
        check("sw_w0_addr", 64'(W0_addr), 64'd0);
        advance();
        drive(1'b0, 64'h0, 1'b0);
        check("sw_r0_en", 64'(R0_en), 64'd1);
        check("sw_r0_addr", 64'(R0_addr), 64'd0);
        advance();
        drive(1'b0, 64'h0, 1'b0);
        check("sw_deq_valid_t2", 64'(deq_valid), 64'd0);
        advance();
        drive(1'b0, 64'h0, 1'b1);
        check("sw_deq_valid_t3", 64'(deq_valid), 64'd1);
        check("sw_deq_bits", deq_bits, 64'hA5);
        check("sw_count_t3", 64'(count), 64'd1);
        advance();
        drive(1'b0, 64'h0, 1'b0);
        check("sw_deq_valid_after", 64'(deq_valid), 64'd0);
        check("sw_count_after", 64'(count), 64'd0);
        advance();

        // Fill with no consumer: 48 in memory + 2 in the output buffer
        k = 0;
        for (int c = 0; c < 60; c++) begin
            drive(1'b1, 64'(k), 1'b0);
            acc = enq_ready;
            advance();
            if (acc) k++;
        end
        check("fill_accepted", 64'(k), 64'd50);
        drive(1'b1, 64'd999, 1'b0);
        check("full_enq_ready", 64'(enq_ready), 64'd0);
        check("full_w0_en", 64'(W0_en), 64'd0);
        check("full_count", 64'(count), 64'd50);
        advance();
        for (int c = 0; c < 60; c++) begin
            drive(1'b0, 64'h0, 1'b1);
            advance();
        end
        drive(1'b0, 64'h0, 1'b0);
        check("drain_count", 64'(count), 64'd0);
        check("drain_deq_valid", 64'(deq_valid), 64'd0);
        advance();

        // Streaming across the address wrap
        sent = 0;
        win_deq = 0;
        for (int c = 0; c < 230; c++) begin
            drive(sent < 200, 64'(1000 + sent), 1'b1);
            acc = enq_valid && enq_ready;
            if (c >= 20 && c < 180 && deq_valid) win_deq++;
            advance();
            if (acc) sent++;
        end
        check("wrap_sent", 64'(sent), 64'd200);
        check("wrap_throughput", 64'(win_deq), 64'd160);
        check("wrap_empty", 64'(sbq.size()), 64'd0);

        // Random valid/ready
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            ev = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            drive(ev, {$urandom, $urandom}, dr);
            acc = enq_valid && enq_ready;
            advance();
            if (acc) sent++;
            cyc++;
        end
        check("rand_sent", 64'(sent), 64'd10000);
        cyc = 0;
        while (sbq.size() > 0 && cyc < 200) begin
            drive(1'b0, 64'h0, 1'b1);
            advance();
            cyc++;
        end
        check("rand_drained", 64'(sbq.size()), 64'd0);

        // Reset with stored words and a read in flight
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'(256 + i), 1'b0);
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b0);
            advance();
        end
        drive(1'b0, 64'h0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd10);
        advance();
        drive(1'b0, 64'h0, 1'b1);
        check("pre_rst_r0_en", 64'(R0_en), 64'd1);
        advance();
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            check("post_rst_deq_valid", 64'(deq_valid), 64'd0);
            advance();
        end
        drive(1'b1, 64'h1, 1'b0);
        advance();
        drive(1'b0, 64'h0, 1'b0);
        advance();
        drive(1'b0, 64'h0, 1'b0);
        advance();
        drive(1'b0, 64'h0, 1'b1);
        check("post_rst_first_valid", 64'(deq_valid), 64'd1);
        check("post_rst_first_word", deq_bits, 64'h1);
        advance();
        drive(1'b0, 64'h0, 1'b0);
        check("post_rst_final_count", 64'(count), 64'd0);
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_1r1w_fifo_ctrl.md
MEM_1R1W_FIFO_CTRL -- requirements
Module: mem_1r1w_fifo_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 48, number of words in the attached mem_1r1w instance.
REQ-002 SHALL provide parameter WIDTH, default 64, data word width in bits.
REQ-003 SHALL provide parameter ADDR_W, default 6, address width; DEPTH <= 2^ADDR_W.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports named as below.
REQ-005 clock  input  1  sole clock; also drives the W0_clk and R0_clk pins of the memory.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enq_valid  input  1  producer has a word.
REQ-008 enq_ready  output  1  controller accepts a word this cycle.
REQ-009 enq_bits  input  WIDTH  producer word.
REQ-010 deq_valid  output  1  head word is available on deq_bits.
REQ-011 deq_ready  input  1  consumer takes the head word this cycle.
REQ-012 deq_bits  output  WIDTH  head word.
REQ-013 count  output  6  total words held; range 0..DEPTH+2.
REQ-014 W0_addr / W0_en / W0_data  output  ADDR_W / 1 / WIDTH  memory write port.
REQ-015 R0_addr / R0_en  output  ADDR_W / 1  memory read port request.
REQ-016 R0_data  input  WIDTH  memory read data, valid exactly 1 cycle after R0_en.

Function
REQ-017 Transfers SHALL occur on enq_valid&enq_ready and on deq_valid&deq_ready, sampled at the rising clock edge; order SHALL be strict FIFO.
REQ-018 State: wr_ptr and rd_ptr (0..DEPTH-1), mem_cnt (0..DEPTH), rd_inflight (1 bit), 2-entry output buffer ob (ob_cnt 0..2).
REQ-019 enq_ready SHALL equal (mem_cnt != DEPTH), decoded from registers only.
REQ-020 On enqueue: W0_en=1, W0_addr=wr_ptr, W0_data=enq_bits in the same cycle; wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-021 A read SHALL issue (R0_en=1, R0_addr=rd_ptr) when mem_cnt>0 and ob_cnt+rd_inflight < 2, or ob_cnt+rd_inflight == 2 with a dequeue this cycle; rd_ptr increments with the same wrap rule.
REQ-022 mem_cnt SHALL be incremented by enqueue and decremented by read issue; both in one cycle leave it unchanged.
REQ-023 rd_inflight SHALL be set by read issue; in the next cycle R0_data SHALL be written to the tail of ob.
REQ-024 deq_valid SHALL equal (ob_cnt != 0); deq_bits SHALL be the ob head, registered.
REQ-025 Simultaneous ob capture and dequeue SHALL keep ob_cnt unchanged and preserve order.
REQ-026 count SHALL equal mem_cnt + rd_inflight + ob_cnt, registered.
REQ-027 Latency SHALL be: enqueue in cycle t into an empty controller -> read issued t+1 -> captured end of t+2 -> deq_valid high in t+3.
REQ-028 Sustained throughput SHALL be 1 word/cycle with enq_valid and deq_ready held high.
REQ-029 A read SHALL never target the address written in the same cycle; this follows from REQ-021, which uses the registered mem_cnt.
REQ-030 Full condition: with mem_cnt==DEPTH, enq_ready=0 and W0_en=0 regardless of enq_valid.
REQ-031 Empty condition: deq_valid=0; deq_ready is ignored and ob and count do not change.

Reset
REQ-032 While reset=1: wr_ptr, rd_ptr, mem_cnt, rd_inflight and ob_cnt SHALL be 0, W0_en=0, R0_en=0, deq_valid=0, count=0; enq and deq handshakes are ignored.
REQ-033 After reset deasserts, enq_ready SHALL be 1 from the first cycle.
REQ-034 Reset mid-operation SHALL discard all stored words and any in-flight read; R0_data in the following cycle SHALL NOT be captured.
REQ-035 ob data registers are don't-care after reset; deq_bits is unspecified while deq_valid=0.

Verification
REQ-036 Single word: enqueue 0xA5 at cycle 0 after reset -> R0_en at 1 with R0_addr=0, deq_valid at 3 with deq_bits=0xA5, count 1 then 0 after dequeue.
REQ-037 Fill: deq_ready=0, enqueue 60 words 0..59 -> 50 accepted (words 0..49), enq_ready=0 once mem_cnt=48, count=50; drain gives 0..49 in order.
REQ-038 Wrap: 200 words streamed with enq_valid=deq_ready=1 -> W0_addr and R0_addr wrap 47->0, output is in order, 1 word/cycle in steady state.
REQ-039 Backpressure: random deq_ready (50%) with random enq_valid, 10k words -> scoreboard match, no word lost or duplicated, count always equals the model occupancy.
REQ-040 Reset with 10 words stored and a read in flight -> next cycle count=0, deq_valid=0, no stale word appears; a new word 0x1 is dequeued first.
